// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: widths, memory-op and
// FSM encodings, the default bus timeout, and small decode helpers.
package mem_access_pkg;

  localparam int REG_ADDR_WIDTH  = 5;
  localparam int REG_DATA_WIDTH  = 32;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Halfword ops need an even address, word ops a multiple of four.
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return |off;
      default:              return 1'b0;
    endcase
  endfunction

  // Little-endian byte enables; loads always fetch the whole word.
  function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_SB:   return 4'b0001 << off;
      OP_SH:   return off[1] ? 4'b1100 : 4'b0011;
      OP_SW:   return 4'b1111;
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Narrow store data is replicated so every enabled lane sees it.
  function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] data);
    case (op)
      OP_SB:   return {4{data[7:0]}};
      OP_SH:   return {2{data[15:0]}};
      OP_SW:   return data;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load-data lane selection and sign/zero extension for a returned bus word.
module load_ext
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/halfword and extend it according to the op.
  always_comb begin
    byte_lane = 8'(rdata >> {addr, 3'b000});
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    result    = rdata;
    case (op)
      OP_LB:   result = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  result = {24'd0, byte_lane};
      OP_LH:   result = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  result = {16'd0, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes non-memory results through, and runs loads and
// stores on a simple req/ack bus with a stall, misalignment check and timeout.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
  input  logic [REG_DATA_WIDTH-1:0] w_reg_data_in,
  input  logic                      w_reg_en_in,
  input  logic [3:0]                mem_op_in,
  input  logic [31:0]               store_data_in,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [31:0]               bus_addr,
  output logic [3:0]                bus_be,
  output logic [31:0]               bus_wdata,
  input  logic                      bus_ack,
  input  logic [31:0]               bus_rdata,
  output logic [REG_ADDR_WIDTH-1:0] w_reg_addr_out,
  output logic [REG_DATA_WIDTH-1:0] w_reg_data_out,
  output logic                      w_reg_en_out,
  output logic                      stall_req,
  output logic                      misalign_exc,
  output logic                      bus_err_exc
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         op_q;
  logic [1:0]         off_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [31:0]        load_val;
  logic [1:0]         off;
  logic               is_mem;
  logic               misaligned;
  logic               start;
  logic               timeout;

  assign off        = w_reg_data_in[1:0];
  assign is_mem     = op_is_load(mem_op_in) || op_is_store(mem_op_in);
  assign misaligned = op_misaligned(mem_op_in, off);
  // Last BUSY cycle that may still wait for an ack.
  assign timeout    = (cnt_q == CNT_W'(TIMEOUT - 1));

  assign w_reg_addr_out = w_reg_addr_in;
  assign bus_err_exc    = err_q;

  // The op and offset are latched at issue so the returned word is decoded
  // against the access actually on the bus.
  load_ext u_load_ext (
    .op     (op_q),
    .addr   (off_q),
    .rdata  (bus_rdata),
    .result (load_val)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus the combinational stall/exception/writeback outputs.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    start          = 1'b0;
    stall_req      = 1'b0;
    misalign_exc   = 1'b0;
    w_reg_data_out = w_reg_data_in;
    w_reg_en_out   = w_reg_en_in;
    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          w_reg_en_out = 1'b0;
          if (misaligned) begin
            misalign_exc = 1'b1;
          end else begin
            stall_req = 1'b1;
            start     = 1'b1;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall_req    = 1'b1;
        w_reg_en_out = 1'b0;
        if (bus_ack || timeout) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (op_is_load(op_q) && !err_q) w_reg_data_out = rdata_q;
        else                            w_reg_en_out   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus request registers, timeout counter, captured load data and error flag.
  // NOTE: the captured data register is reset too, so nothing from an aborted access survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= op_is_store(mem_op_in);
            bus_addr  <= {w_reg_data_in[31:2], 2'b00};
            bus_be    <= lane_be(mem_op_in, off);
            bus_wdata <= store_wdata(mem_op_in, store_data_in);
            op_q      <= mem_op_in;
            off_q     <= off;
            cnt_q     <= '0;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            rdata_q <= load_val;
          end else if (timeout) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
